// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// Holds the segment table, the anode codes and the scan FSM state type.
package seg7_pkg;

  localparam int DIGIT_W = 5;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low g..a patterns; entry index equals the hex value shown.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  localparam logic [3:0] ANODE_IDLE = 4'b1111;
  localparam logic [3:0] ANODE_POS0 = 4'b1110;
  localparam logic [3:0] ANODE_POS1 = 4'b1101;
  localparam logic [3:0] ANODE_POS2 = 4'b1011;
  localparam logic [3:0] ANODE_POS3 = 4'b0111;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    EXP1 = 3'd1,
    EXP2 = 3'd2,
    EXP3 = 3'd3,
    EXP0 = 3'd4
  } scan_state_t;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] hex;
  } seg_dec_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern decoder: active-low g..a pattern to
// {valid, blank, hex}. Unrecognised patterns come back with valid low.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output seg_dec_t   o_dec
);

  logic w_hit;

  // Match against the blank code first, then scan the hex table.
  always_comb begin
    o_dec = '{valid: 1'b0, blank: 1'b0, hex: 4'h0};
    w_hit = 1'b0;
    if (i_pattern == SEG_BLANK) begin
      o_dec = '{valid: 1'b1, blank: 1'b1, hex: 4'hF};
    end else begin
      for (int i = 0; i < 16; i++) begin
        w_hit       = (i_pattern == SEG_TABLE[i[3:0]]);
        o_dec.valid = o_dec.valid | w_hit;
        o_dec.hex   = w_hit ? i[3:0] : o_dec.hex;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers digits from a scanned, multiplexed 4-digit 7-segment bus:
// synchronise, debounce, decode, and track in-order frame sequencing.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anodes,
  input  logic [7:0]  cathodes,
  input  logic        err_clr,
  output logic [19:0] digits,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        frame_pulse,
  output logic        seg_err,
  output logic        seq_err
);

  // Accept fires while the count passes this value with a matching sample,
  // i.e. on the STABLE_CYCLES-th identical synced sample.
  localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 2);

  logic [11:0] r_sync1;
  logic [11:0] r_sync2;
  logic [11:0] r_prev;
  logic [7:0]  r_cnt;
  scan_state_t r_state;
  logic [19:0] r_digits;
  logic [3:0]  r_dp;
  logic        r_frame_valid;
  logic        r_frame_pulse;
  logic        r_seg_err;
  logic        r_seq_err;

  logic        w_accept;
  logic        w_idle;
  logic        w_pos_ok;
  logic        w_illegal;
  logic [1:0]  w_pos;
  logic [1:0]  w_exp_pos;
  logic [1:0]  w_prev_pos;
  logic [4:0]  w_lsb;
  seg_dec_t    w_dec;

  seg7_decode u_decode (
    .i_pattern (r_sync2[6:0]),
    .o_dec     (w_dec)
  );

  assign w_accept   = (r_sync2 == r_prev) && (r_cnt == ACCEPT_CNT);
  assign w_illegal  = !w_idle && !w_pos_ok;
  assign w_prev_pos = w_exp_pos - 2'd1;
  assign w_lsb      = 5'(w_pos) * 5'd5;

  // Classify the synced anode pattern.
  always_comb begin
    w_idle   = 1'b0;
    w_pos_ok = 1'b0;
    w_pos    = 2'd0;
    case (r_sync2[11:8])
      ANODE_IDLE: w_idle = 1'b1;
      ANODE_POS0: begin w_pos_ok = 1'b1; w_pos = 2'd0; end
      ANODE_POS1: begin w_pos_ok = 1'b1; w_pos = 2'd1; end
      ANODE_POS2: begin w_pos_ok = 1'b1; w_pos = 2'd2; end
      ANODE_POS3: begin w_pos_ok = 1'b1; w_pos = 2'd3; end
      default:    w_pos_ok = 1'b0;
    endcase
  end

  // Position each sequencing state is waiting for.
  always_comb begin
    case (r_state)
      EXP1:    w_exp_pos = 2'd1;
      EXP2:    w_exp_pos = 2'd2;
      EXP3:    w_exp_pos = 2'd3;
      default: w_exp_pos = 2'd0;
    endcase
  end

  // Two-flop synchroniser and saturating stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_cnt   <= 8'd0;
    end else begin
      r_sync1 <= {anodes, cathodes};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_sync2 != r_prev) begin
        r_cnt <= 8'd0;
      end else if (r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Capture, sequencing FSM and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= HUNT;
      r_digits      <= 20'hFFFFF;
      r_dp          <= 4'b0000;
      r_frame_valid <= 1'b0;
      r_frame_pulse <= 1'b0;
      r_seg_err     <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      r_frame_pulse <= 1'b0;
      // Later assignments of 1 below override the clear, so events win.
      r_seg_err     <= r_seg_err & ~err_clr;
      r_seq_err     <= r_seq_err & ~err_clr;
      if (w_accept && w_illegal) begin
        r_seq_err     <= 1'b1;
        r_frame_valid <= 1'b0;
        r_state       <= HUNT;
      end else if (w_accept && w_pos_ok) begin
        if (w_dec.valid) begin
          r_digits[w_lsb +: DIGIT_W] <= {w_dec.blank, w_dec.hex};
          r_dp[w_pos]                <= ~r_sync2[7];
        end else begin
          r_seg_err <= 1'b1;
        end
        if (r_state == HUNT) begin
          if (w_pos == 2'd0) begin
            r_state <= EXP1;
          end
        end else if (w_pos == w_exp_pos) begin
          case (r_state)
            EXP1: r_state <= EXP2;
            EXP2: r_state <= EXP3;
            EXP3: begin
              r_state       <= EXP0;
              r_frame_pulse <= 1'b1;
              r_frame_valid <= 1'b1;
            end
            default: r_state <= EXP1;
          endcase
        end else if (w_pos != w_prev_pos) begin
          r_seq_err     <= 1'b1;
          r_frame_valid <= 1'b0;
          r_state       <= (w_pos == 2'd0) ? EXP1 : HUNT;
        end
      end
    end
  end

  assign digits      = r_digits;
  assign dp          = r_dp;
  assign frame_valid = r_frame_valid;
  assign frame_pulse = r_frame_pulse;
  assign seg_err     = r_seg_err;
  assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with STABLE_CYCLES = 4.
module tb_seg7_scan_decoder;

  logic        clk;
  logic        reset;
  logic [3:0]  anodes;
  logic [7:0]  cathodes;
  logic        err_clr;
  logic [19:0] digits;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        frame_pulse;
  logic        seg_err;
  logic        seq_err;

  int n_vec;
  int n_err;
  int n_pulse;

  seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .anodes      (anodes),
    .cathodes    (cathodes),
    .err_clr     (err_clr),
    .digits      (digits),
    .dp          (dp),
    .frame_valid (frame_valid),
    .frame_pulse (frame_pulse),
    .seg_err     (seg_err),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  // Counts every cycle frame_pulse is high, so a wide pulse shows up too.
  always @(negedge clk) begin
    if (frame_pulse === 1'b1) n_pulse++;
  end

  task automatic drive(input logic [3:0] an, input logic [7:0] ca, input int n);
    anodes   = an;
    cathodes = ca;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; anodes = 4'hF; cathodes = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_vec++; if (digits !== 20'hFFFFF) begin n_err++; $display("FAIL reset_digits: got %h want %h", digits, 20'hFFFFF); end
    n_vec++; if (dp !== 4'b0000) begin n_err++; $display("FAIL reset_dp: got %b want 0000", dp); end
    n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    n_vec++; if (frame_pulse !== 1'b0) begin n_err++; $display("FAIL reset_fp: got %b want 0", frame_pulse); end
    n_vec++; if ({seg_err, seq_err} !== 2'b00) begin n_err++; $display("FAIL reset_errs: got %b want 00", {seg_err, seq_err}); end
  endtask

  task automatic test_latency;
    // 8'h19: dp lit, pattern for 4
    drive(4'b1110, 8'h19, 5);
    n_vec++; if (digits !== 20'hFFFFF) begin n_err++; $display("FAIL latency_early: got %h want %h", digits, 20'hFFFFF); end
    @(posedge clk); #1;
    n_vec++; if (digits !== 20'hFFFE4) begin n_err++; $display("FAIL latency_digits: got %h want %h", digits, 20'hFFFE4); end
    n_vec++; if (dp !== 4'b0001) begin n_err++; $display("FAIL latency_dp: got %b want 0001", dp); end
    drive(4'b1110, 8'h19, 4);
  endtask

  task automatic test_scan;
    int p0;
    p0 = n_pulse;
    drive(4'b1110, 8'hC0, 10);
    drive(4'b1101, 8'hF9, 10);
    drive(4'b1011, 8'hA4, 10);
    drive(4'b0111, 8'hB0, 10);
    n_vec++; if (digits !== 20'h18820) begin n_err++; $display("FAIL scan_digits: got %h want %h", digits, 20'h18820); end
    n_vec++; if (dp !== 4'b0000) begin n_err++; $display("FAIL scan_dp: got %b want 0000", dp); end
    n_vec++; if (n_pulse - p0 !== 1) begin n_err++; $display("FAIL scan_pulses: got %0d want 1", n_pulse - p0); end
    n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL scan_fv: got %b want 1", frame_valid); end
    n_vec++; if ({seg_err, seq_err} !== 2'b00) begin n_err++; $display("FAIL scan_errs: got %b want 00", {seg_err, seq_err}); end
  endtask

  task automatic test_glitch;
    int p0;
    p0 = n_pulse;
    drive(4'b1110, 8'hC0, 10);
    drive(4'b1110, 8'hF9, 3);
    drive(4'b1110, 8'hC0, 10);
    n_vec++; if (digits !== 20'h18820) begin n_err++; $display("FAIL glitch_digits: got %h want %h", digits, 20'h18820); end
    n_vec++; if (n_pulse != p0) begin n_err++; $display("FAIL glitch_pulses: got %0d want 0", n_pulse - p0); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL glitch_seq: got %b want 0", seq_err); end
  endtask

  task automatic test_seg_err;
    drive(4'b1101, 8'hAA, 10);
    n_vec++; if (seg_err !== 1'b1) begin n_err++; $display("FAIL segerr_set: got %b want 1", seg_err); end
    n_vec++; if (digits !== 20'h18820) begin n_err++; $display("FAIL segerr_digits: got %h want %h", digits, 20'h18820); end
    drive(4'hF, 8'hFF, 2);
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    n_vec++; if (seg_err !== 1'b0) begin n_err++; $display("FAIL segerr_clr: got %b want 0", seg_err); end
    drive(4'b1011, 8'hA4, 10);
    drive(4'b0111, 8'hB0, 10);
    n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL segerr_fv: got %b want 1", frame_valid); end
  endtask

  task automatic test_seq_err;
    int p0;
    drive(4'b1110, 8'hC0, 10);
    drive(4'b1011, 8'hA4, 10);
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_set: got %b want 1", seq_err); end
    n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL seq_fv: got %b want 0", frame_valid); end
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_clr: got %b want 0", seq_err); end
    // position 3 is ignored only if the FSM really fell back to HUNT
    drive(4'b0111, 8'hB0, 10);
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_hunt: got %b want 0", seq_err); end
    p0 = n_pulse;
    drive(4'b1110, 8'h92, 10);
    drive(4'b1101, 8'h02, 10);
    drive(4'b1011, 8'h78, 10);
    drive(4'b0111, 8'hFF, 10);
    n_vec++; if (n_pulse - p0 !== 1) begin n_err++; $display("FAIL seq_rescan_pulse: got %0d want 1", n_pulse - p0); end
    n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL seq_rescan_fv: got %b want 1", frame_valid); end
    n_vec++; if (digits !== 20'hF9CC5) begin n_err++; $display("FAIL seq_rescan_digits: got %h want %h", digits, 20'hF9CC5); end
    n_vec++; if (dp !== 4'b0110) begin n_err++; $display("FAIL seq_rescan_dp: got %b want 0110", dp); end
  endtask

  task automatic test_illegal;
    drive(4'b1100, 8'h80, 5);
    // err_clr lands in the same cycle as the accept; the error must win
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL illegal_seq: got %b want 1", seq_err); end
    n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL illegal_fv: got %b want 0", frame_valid); end
    drive(4'b1100, 8'h80, 4);
    n_vec++; if (digits !== 20'hF9CC5) begin n_err++; $display("FAIL illegal_digits: got %h want %h", digits, 20'hF9CC5); end
    n_vec++; if (dp !== 4'b0110) begin n_err++; $display("FAIL illegal_dp: got %b want 0110", dp); end
    drive(4'hF, 8'hFF, 5);
  endtask

  task automatic test_reset_mid;
    drive(4'b1110, 8'hC0, 10);
    drive(4'b1101, 8'hF9, 10);
    reset = 1'b1; anodes = 4'hF; cathodes = 8'hFF;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++; if (digits !== 20'hFFFFF) begin n_err++; $display("FAIL midrst_digits: got %h want %h", digits, 20'hFFFFF); end
    n_vec++; if (dp !== 4'b0000) begin n_err++; $display("FAIL midrst_dp: got %b want 0000", dp); end
    n_vec++; if ({frame_valid, frame_pulse, seg_err, seq_err} !== 4'b0000) begin n_err++; $display("FAIL midrst_flags: got %b want 0000", {frame_valid, frame_pulse, seg_err, seq_err}); end
    drive(4'b0111, 8'h86, 10);
    n_vec++; if (digits !== 20'h77FFF) begin n_err++; $display("FAIL midrst_capture: got %h want %h", digits, 20'h77FFF); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL midrst_hunt: got %b want 0", seq_err); end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; anodes = 4'hF; cathodes = 8'hFF; err_clr = 1'b0;
    n_vec = 0; n_err = 0; n_pulse = 0;
    test_reset;
    test_latency;
    test_scan;
    test_glitch;
    test_seg_err;
    test_seq_err;
    test_illegal;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: STABLE_CYCLES, default 4, consecutive identical synced samples required before a sample is accepted (legal 2..255).
REQ-003 Port: clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: anodes  input  4  scanned digit enables, active-low, bit n = position n.
REQ-006 Port: cathodes  input  8  active-low segments; bit7 = dp, bits6:0 = g..a.
REQ-007 Port: err_clr  input  1  clears sticky error flags.
REQ-008 Port: digits  output  20  recovered digits; position n at [5n+4:5n] = {blank, hex[3:0]}.
REQ-009 Port: dp  output  4  recovered decimal points, 1 = lit.
REQ-010 Port: frame_valid  output  1  complete in-order frame captured since last seq error.
REQ-011 Port: frame_pulse  output  1  one-cycle strobe on in-order frame completion.
REQ-012 Port: seg_err  output  1  sticky: unrecognised segment pattern accepted.
REQ-013 Port: seq_err  output  1  sticky: illegal anode pattern or out-of-order position.

Function
REQ-014 anodes and cathodes SHALL pass through a 2-flop synchroniser (12 bits).
REQ-015 Stabiliser: counter clears when synced sample differs from previous synced sample, else increments, saturating; exactly one accept per stable period when STABLE_CYCLES consecutive equal samples are seen.
REQ-016 Latency: input change held stable -> outputs update STABLE_CYCLES+2 clocks later; shorter pulses SHALL be ignored.
REQ-017 Accepted anodes 4'b1111 = idle: no capture, no state change, no error.
REQ-018 Accepted anodes one-hot-low (1110,1101,1011,0111) = position 0..3; any other value SHALL set seq_err with no capture.
REQ-019 Decode cathodes[6:0] (active-low) to hex 0-F per team table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 cathodes[6:0]=1111111 SHALL decode as blank: digit field 5'b11111.
REQ-021 Any other pattern SHALL set seg_err; that position's digit and dp unchanged.
REQ-022 Valid accepted position SHALL update its digit field and dp bit (dp = ~cathodes[7]) on the next edge, regardless of order.
REQ-023 FSM states HUNT, EXP1, EXP2, EXP3, EXP0; reset -> HUNT.
REQ-024 HUNT: position 0 -> EXP1; positions 1-3 ignored for sequencing, no error.
REQ-025 EXPn: position n -> next state (EXP1->EXP2->EXP3); EXP3 with position 3 -> frame_pulse=1 one cycle, frame_valid=1, -> EXP0; EXP0 with position 0 -> EXP1.
REQ-026 Repeat accept of the previously captured position SHALL update data only, no state change, no error.
REQ-027 Any other position in EXPn SHALL set seq_err, clear frame_valid, go to EXP1 if position 0 else HUNT.
REQ-028 Illegal anode pattern SHALL also clear frame_valid and go to HUNT.
REQ-029 err_clr clears both sticky flags next edge; a same-cycle error event wins (flag stays 1).

Reset
REQ-030 On reset: digits=20'hFFFFF, dp=4'b0000, frame_valid=0, frame_pulse=0, seg_err=0, seq_err=0, FSM=HUNT, stabiliser count=0, synchroniser and previous-sample registers=all ones.
REQ-031 Reset asserted mid-scan SHALL take effect on the next edge, discarding any partial frame.

Structure
REQ-032 Shared package seg7_pkg SHALL hold the 16-entry segment table, blank pattern, one-hot-low anode constants, digit field width (5) and FSM state type.
REQ-033 Pattern->{valid, blank, hex} decode SHALL be a combinational sub-module seg7_decode.

Verification (STABLE_CYCLES=4)
REQ-034 Reset 2 cycles -> digits=20'hFFFFF, dp=0, all flags 0.
REQ-035 Scan 1110/8'hC0, 1101/8'hF9, 1011/8'hA4, 0111/8'hB0, 10 cycles each -> digits=20'h18820, one frame_pulse, frame_valid=1, no errors.
REQ-036 During held 1110/8'hC0, drive 8'hF9 for 3 cycles then back -> digits unchanged, no pulse.
REQ-037 Position 1 with 8'hAA -> seg_err=1, digit1 unchanged; err_clr 1 cycle -> seg_err=0.
REQ-038 Position 0 then position 2 -> seq_err=1, frame_valid=0, FSM HUNT; next full in-order scan -> frame_pulse.
REQ-039 Anodes 4'b1100 -> seq_err=1, no capture; reset asserted in EXP2 -> all REQ-030 values next edge.
